whack_game_ctrl: RTL and testbench



---
 rtl/whack_pkg.sv | 31 +++
 rtl/mole_lfsr.sv | 25 ++
 rtl/whack_game_ctrl.sv | 171 +++++++++++++++++
 tb/tb_whack_game_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    FEEDBACK,
    OVER
  } state_e;

  localparam int POS_W = 3;
  localparam int BCD_W = 4;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [2*BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] tens,
                                                     input logic [BCD_W-1:0] ones);
    logic [2*BCD_W-1:0] r;
    r = {tens, ones};
    if (tens == 4'd9 && ones == 4'd9) begin
      r = {tens, ones};
    end else if (ones == 4'd9) begin
      r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used to pick mole holes.
module mole_lfsr
  import whack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole sequencer: spawns moles, times them on tick, judges guesses,
// keeps a saturating two-digit BCD score and stops after ROUNDS moles.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int NUM_HOLES      = 6,
  parameter int ROUNDS         = 20,
  parameter int MOLE_TICKS     = 8,
  parameter int FEEDBACK_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             guess_valid,
  input  logic [POS_W-1:0] guess_pos,
  output logic [POS_W-1:0] mole_position,
  output logic             guess_correct,
  output logic             guess_wrong,
  output logic             game_over,
  output logic [BCD_W-1:0] digit_1,
  output logic [BCD_W-1:0] digit_2
);

  localparam int TMR_MAX = (MOLE_TICKS > FEEDBACK_TICKS) ? MOLE_TICKS : FEEDBACK_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] MOLE_LOAD   = TMR_W'(MOLE_TICKS);
  localparam logic [TMR_W-1:0] FB_LOAD     = TMR_W'(FEEDBACK_TICKS);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [7:0]       ROUNDS_LOAD = 8'(ROUNDS);
  // One extra bit so NUM_HOLES=8 is representable in the hole arithmetic.
  localparam logic [POS_W:0]   HOLES       = (POS_W+1)'(NUM_HOLES);
  localparam logic [POS_W:0]   HOLE_ONE    = (POS_W+1)'(1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]         rounds_q, rounds_d;
  logic [POS_W-1:0]   mole_q, mole_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;
  logic               over_q, over_d;
  logic [BCD_W-1:0]   tens_q, tens_d;
  logic [BCD_W-1:0]   ones_q, ones_d;

  logic [7:0]         lfsr;
  logic               lfsr_unused;
  logic [POS_W:0]     pick_raw;
  logic [POS_W-1:0]   pick;
  logic [2*BCD_W-1:0] score_inc;

  mole_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:POS_W];

  // Fold the raw 3-bit draw into range, then step past the previous hole so
  // the same mole never appears twice in a row.
  always_comb begin
    pick_raw = {1'b0, lfsr[POS_W-1:0]};
    if (pick_raw >= HOLES) begin
      pick_raw = pick_raw - HOLES;
    end
    if (pick_raw[POS_W-1:0] == mole_q) begin
      pick_raw = ((pick_raw + HOLE_ONE) == HOLES) ? '0 : pick_raw + HOLE_ONE;
    end
    pick = pick_raw[POS_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rounds_d  = rounds_q;
    mole_d    = mole_q;
    correct_d = correct_q;
    wrong_d   = wrong_q;
    over_d    = over_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    score_inc = bcd_inc_sat(tens_q, ones_q);
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          tens_d   = '0;
          ones_d   = '0;
          over_d   = 1'b0;
          rounds_d = ROUNDS_LOAD;
          state_d  = SPAWN;
        end
      end
      SPAWN: begin
        mole_d   = pick;
        timer_d  = MOLE_LOAD;
        rounds_d = rounds_q - 8'd1;
        state_d  = UP;
      end
      UP: begin
        // A guess takes priority over a coincident expiring tick.
        if (guess_valid) begin
          if (guess_pos == mole_q) begin
            correct_d        = 1'b1;
            {tens_d, ones_d} = score_inc;
          end else begin
            wrong_d = 1'b1;
          end
          timer_d = FB_LOAD;
          state_d = FEEDBACK;
        end else if (tick) begin
          if (timer_q == TMR_ONE) begin
            wrong_d = 1'b1;
            timer_d = FB_LOAD;
            state_d = FEEDBACK;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      FEEDBACK: begin
        if (tick) begin
          if (timer_q == TMR_ONE) begin
            correct_d = 1'b0;
            wrong_d   = 1'b0;
            if (rounds_q == 8'd0) begin
              over_d  = 1'b1;
              state_d = OVER;
            end else begin
              state_d = SPAWN;
            end
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rounds_q  <= '0;
      mole_q    <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      over_q    <= 1'b0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rounds_q  <= rounds_d;
      mole_q    <= mole_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      over_q    <= over_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign mole_position = mole_q;
  assign guess_correct = correct_q;
  assign guess_wrong   = wrong_q;
  assign game_over     = over_q;
  assign digit_1       = tens_q;
  assign digit_2       = ones_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl: a 3-round instance for game flow and a
// 120-round instance for BCD carry and saturation.
module tb_whack_game_ctrl;
  import whack_pkg::*;

  localparam int NH = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, start, guess_valid;
  logic [2:0] guess_pos;
  logic [2:0] mole_position;
  logic       guess_correct, guess_wrong, game_over;
  logic [3:0] digit_1, digit_2;

  logic       tick_b, start_b, gv_b;
  logic [2:0] gpos_b;
  logic [2:0] mole_b;
  logic       corr_b, wrong_b, over_b;
  logic [3:0] d1_b, d2_b;

  int         n_cmp = 0;
  int         n_err = 0;
  int         sparse = 0;
  int         div = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  whack_game_ctrl #(
    .NUM_HOLES(6), .ROUNDS(3), .MOLE_TICKS(4), .FEEDBACK_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .guess_valid(guess_valid), .guess_pos(guess_pos),
    .mole_position(mole_position), .guess_correct(guess_correct),
    .guess_wrong(guess_wrong), .game_over(game_over),
    .digit_1(digit_1), .digit_2(digit_2)
  );

  whack_game_ctrl #(
    .NUM_HOLES(6), .ROUNDS(120), .MOLE_TICKS(4), .FEEDBACK_TICKS(2)
  ) dut_bcd (
    .clk(clk), .rst(rst), .tick(tick_b), .start(start_b),
    .guess_valid(gv_b), .guess_pos(gpos_b),
    .mole_position(mole_b), .guess_correct(corr_b),
    .guess_wrong(wrong_b), .game_over(over_b),
    .digit_1(d1_b), .digit_2(d2_b)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] m, input logic c,
                           input logic w, input logic o, input logic [3:0] d1,
                           input logic [3:0] d2);
    check_eq({tag, "_mole"}, mole_position, m);
    check_eq({tag, "_correct"}, guess_correct, c);
    check_eq({tag, "_wrong"}, guess_wrong, w);
    check_eq({tag, "_over"}, game_over, o);
    check_eq({tag, "_d1"}, digit_1, d1);
    check_eq({tag, "_d2"}, digit_2, d2);
  endtask

  // ---------------- drivers ----------------
  // Advance to the next falling edge; in sparse mode tick fires once per 5 clk.
  task automatic step();
    @(negedge clk);
    if (sparse != 0) begin
      div  = (div == 4) ? 0 : div + 1;
      tick = (div == 0);
    end else begin
      tick = 1'b1;
    end
  endtask

  task automatic new_mole(input string tag, input logic [2:0] prev, output logic [2:0] m);
    m = mole_position;
    check_eq({tag, "_range"}, (m < NH), 1);
    check_eq({tag, "_differs"}, (m != prev), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] m0, m1, m2, m3, m4, m5, m6;
    logic [7:0] e;
    int         score;
    int         cnt;

    rst = 1'b1; tick = 1'b1; start = 1'b0; guess_valid = 1'b0; guess_pos = '0;
    tick_b = 1'b1; start_b = 1'b0; gv_b = 1'b0; gpos_b = '0;
    repeat (3) @(negedge clk);
    check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    rst = 1'b0;

    // guess in IDLE matches position 0 but must be ignored
    guess_valid = 1'b1; guess_pos = 3'd0; step(); guess_valid = 1'b0;
    check_out("idle_guess", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // BCD carry and saturation on the 120-round instance
    start_b = 1'b1; step(); start_b = 1'b0; step();
    score = 0;
    for (int h = 1; h <= 100; h++) begin
      gv_b = 1'b1; gpos_b = mole_b; step(); gv_b = 1'b0;
      score = (score < 99) ? score + 1 : 99;
      exp_q.push_back({4'(score / 10), 4'(score % 10)});
      check_eq($sformatf("bcd_flag_%0d", h), corr_b, 1);
      e = exp_q.pop_front();
      check_eq($sformatf("bcd_digits_%0d", h), {d1_b, d2_b}, e);
      repeat (3) step();
    end

    // game 1, round 1: correct hit
    start = 1'b1; step(); start = 1'b0;
    step();
    new_mole("r1_mole", 3'd0, m0);
    guess_valid = 1'b1; guess_pos = m0; step(); guess_valid = 1'b0;
    check_out("r1_hit", m0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
    step(); check_eq("r1_hold", guess_correct, 1);
    step(); check_eq("r1_clear", guess_correct, 0);
    step(); new_mole("r2_mole", m0, m1);

    // round 2: wrong guess
    guess_valid = 1'b1; guess_pos = 3'((m1 + 1) % NH); step(); guess_valid = 1'b0;
    check_out("r2_wrong", m1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
    step(); check_eq("r2_hold", guess_wrong, 1);
    step(); check_eq("r2_clear", guess_wrong, 0);
    step(); new_mole("r3_mole", m1, m2);

    // round 3: miss after the 4th tick in UP
    repeat (3) step();
    check_eq("r3_pre_miss", guess_wrong, 0);
    step(); check_out("r3_miss", m2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
    step();
    step(); check_out("over", m2, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
    guess_valid = 1'b1; guess_pos = m2; step(); guess_valid = 1'b0;
    check_out("over_guess", m2, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
    repeat (5) step();
    check_eq("over_hold", game_over, 1);

    // restart from OVER
    start = 1'b1; step(); start = 1'b0;
    check_out("restart", m2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(); new_mole("g2_mole", m2, m3);

    // guess coincident with the expiring tick wins
    repeat (3) step();
    check_eq("coinc_pre", guess_wrong, 0);
    guess_valid = 1'b1; guess_pos = m3; step(); guess_valid = 1'b0;
    check_out("coinc_hit", m3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
    step(); step(); step();
    new_mole("g2r2_mole", m3, m4);

    // asynchronous reset between edges, mid-UP
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check_eq("async_rst_state", dut.state_q, IDLE);
    step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); new_mole("post_rst_mole", 3'd0, m5);
    check_out("post_rst", m5, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    guess_valid = 1'b1; guess_pos = m5; step(); guess_valid = 1'b0;
    check_out("post_rst_hit", m5, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
    step(); step(); step();
    new_mole("sparse_mole", m5, m6);

    // sparse tick: timeout about 20 clk after UP entry
    sparse = 1; div = 0; tick = 1'b0;
    cnt = 0;
    while (!guess_wrong && cnt < 60) begin
      step();
      cnt++;
    end
    check_eq("sparse_timeout_seen", guess_wrong, 1);
    check_eq("sparse_timeout_window", (cnt >= 15 && cnt <= 25), 1);

    // start and guess during FEEDBACK change nothing
    guess_valid = 1'b1; guess_pos = m6; start = 1'b1; step();
    guess_valid = 1'b0; start = 1'b0;
    check_out("fb_ignore", m6, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
